// File: rtl/seg_scan_if.sv
// seg_scan_if: display-side bus of the seven-segment scan controller
// (the blink input exists only when SEG_BLINK_EN is defined)
interface seg_scan_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [4:0] wr_data;
  logic       preset_ld;
  logic [1:0] preset_sel;
  logic [3:0] digit_mask;
`ifdef SEG_BLINK_EN
  logic       blink;
`endif
  logic [4:0] bin_out;
  logic [3:0] anode_n;
  logic [1:0] scan_idx;
  modport master (
    output wr_en, wr_addr, wr_data, preset_ld, preset_sel, digit_mask,
`ifdef SEG_BLINK_EN
    output blink,
`endif
    input  bin_out, anode_n, scan_idx
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, preset_ld, preset_sel, digit_mask,
`ifdef SEG_BLINK_EN
    input  blink,
`endif
    output bin_out, anode_n, scan_idx
  );
endinterface

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: 4-digit time-multiplexed seven-segment scanner with preset messages.
// Define SEG_BLINK_EN to add the blink input and blink phase counter.
module seg_scan_controller #(
`ifdef SEG_BLINK_EN
  parameter int BLINK_DIV = 50,
`endif
  parameter int CLK_DIV = 100000
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [4:0] C_O = 5'b00000, C_P = 5'b10010, C_E = 5'b01110, C_N = 5'b01100;
  localparam logic [4:0] C_C = 5'b01111, C_L = 5'b01101, C_D = 5'b10100, C_DASH = 5'b10001;
  logic [DW-1:0] r_div;
  logic [1:0]    r_scan;
  logic [4:0]    r_digit [4];
  logic [4:0]    r_bin;
  logic [3:0]    r_anode;
  logic [3:0]    w_anode;
  logic [19:0]   w_msg;
  logic          w_tick;
  logic          w_preset;
  logic          w_blank;
  assign w_tick   = r_div == DW'(CLK_DIV - 1);
  assign w_preset = bus.preset_ld && bus.preset_sel != 2'd3;
  // message packed as {digit3, digit2, digit1, digit0}
  always_comb w_msg = bus.preset_sel == 2'd0 ? {4{C_DASH}} :
                      bus.preset_sel == 2'd1 ? {C_O, C_P, C_E, C_N} : {C_C, C_L, C_O, C_D};
`ifdef SEG_BLINK_EN
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic          w_bwrap;
  assign w_bwrap = r_bcnt == BW'(BLINK_DIV - 1);
  assign w_blank = bus.blink && r_phase;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_tick) begin
      r_bcnt  <= w_bwrap ? '0 : r_bcnt + 1'b1;
      r_phase <= r_phase ^ w_bwrap;
    end
  end
`else
  assign w_blank = 1'b0;
`endif
  always_comb w_anode = w_blank ? 4'b1111 : ~(4'b0001 << r_scan) | {4{~bus.digit_mask[r_scan]}};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_scan  <= 2'd0;
      r_bin   <= C_DASH;
      r_anode <= 4'b1111;
      for (int i = 0; i < 4; i++) r_digit[i] <= C_DASH;
    end else begin
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      r_scan  <= w_tick ? r_scan + 2'd1 : r_scan;
      r_bin   <= r_digit[r_scan];
      r_anode <= w_anode;
      if (w_preset)
        for (int i = 0; i < 4; i++) r_digit[i] <= w_msg[i*5 +: 5];
      else if (bus.wr_en)
        r_digit[bus.wr_addr] <= bus.wr_data;
    end
  end
  assign bus.bin_out  = r_bin;
  assign bus.anode_n  = r_anode;
  assign bus.scan_idx = r_scan;
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: directed checks of scan timing, presets, writes, masking, reset and blink
module tb_seg_scan_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mask = 4'b1111;
  logic       blink = 1'b0;
  logic [4:0] exp_code [4];
  int         cyc = 0;
  int         n_run = 0;
  int         n_fail = 0;
  seg_scan_if bus();
  assign bus.digit_mask = mask;
`ifdef SEG_BLINK_EN
  assign bus.blink = blink;
  seg_scan_controller #(.BLINK_DIV(2), .CLK_DIV(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  seg_scan_controller #(.CLK_DIV(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic set_exp(input logic [4:0] e0, e1, e2, e3);
    exp_code[0] = e0;
    exp_code[1] = e1;
    exp_code[2] = e2;
    exp_code[3] = e3;
  endtask
  // cyc counts edges since reset release; dwell of output digit d spans cyc 4d+1..4d+4
  task automatic run(input int n);
    int d;
    int ph;
    logic [3:0] ea;
    for (int k = 0; k < n; k++) begin
      step();
      d  = ((cyc - 1) / 4) % 4;
      ph = ((cyc - 1) / 8) % 2;
      ea = ((blink && ph == 1) || !mask[d]) ? 4'b1111 : ~(4'b0001 << d);
      chk($sformatf("anode c%0d", cyc), 32'(bus.anode_n), 32'(ea));
      chk($sformatf("bin c%0d", cyc), 32'(bus.bin_out), 32'(exp_code[d]));
      chk($sformatf("scan c%0d", cyc), 32'(bus.scan_idx), 32'((cyc / 4) % 4));
    end
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_addr = 2'd0;
    bus.wr_data = 5'd0;
    bus.preset_ld = 1'b0;
    bus.preset_sel = 2'd0;
    set_exp(5'b10001, 5'b10001, 5'b10001, 5'b10001);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst anode", 32'(bus.anode_n), 32'b1111);
      chk("rst bin", 32'(bus.bin_out), 32'b10001);
      chk("rst scan", 32'(bus.scan_idx), 32'd0);
    end
    rst_n = 1'b1;
    cyc = 0;
    run(20);
    bus.preset_ld = 1'b1;
    bus.preset_sel = 2'd1;
    step();
    bus.preset_ld = 1'b0;
    set_exp(5'b01100, 5'b01110, 5'b10010, 5'b00000);
    run(16);
    bus.preset_ld = 1'b1;
    bus.preset_sel = 2'd3;
    step();
    bus.preset_ld = 1'b0;
    run(16);
    bus.preset_ld = 1'b1;
    bus.preset_sel = 2'd2;
    bus.wr_en = 1'b1;
    bus.wr_addr = 2'd2;
    bus.wr_data = 5'b00101;
    step();
    bus.preset_ld = 1'b0;
    bus.wr_en = 1'b0;
    set_exp(5'b10100, 5'b00000, 5'b01101, 5'b01111);
    run(16);
    bus.wr_en = 1'b1;
    step();
    bus.wr_en = 1'b0;
    set_exp(5'b10100, 5'b00000, 5'b00101, 5'b01111);
    run(16);
    mask = 4'b1010;
    run(16);
    mask = 4'b1111;
    for (int k = 0; k < 16 && bus.scan_idx != 2'd2; k++) step();
    chk("reach idx2", 32'(bus.scan_idx), 32'd2);
    rst_n = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_addr = 2'd0;
    bus.wr_data = 5'b00111;
    step();
    rst_n = 1'b1;
    bus.wr_en = 1'b0;
    chk("midrst anode", 32'(bus.anode_n), 32'b1111);
    chk("midrst bin", 32'(bus.bin_out), 32'b10001);
    chk("midrst scan", 32'(bus.scan_idx), 32'd0);
    cyc = 0;
    set_exp(5'b10001, 5'b10001, 5'b10001, 5'b10001);
    run(16);
`ifdef SEG_BLINK_EN
    blink = 1'b1;
    run(32);
    blink = 1'b0;
    run(16);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
